// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, mode encoding and width helpers for the Sobel edge stage
package sobel_pkg;

  // Output mode encoding as seen on the mode input
  typedef enum logic [1:0] {
    MODE_BIN     = 2'b00,
    MODE_BIN_INV = 2'b01,
    MODE_MAG     = 2'b10,
    MODE_BYP     = 2'b11
  } mode_e;

  // Frame-position tags that travel alongside each pipeline stage
  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  // Gradient/magnitude width: 8*(2^DATA_W-1) needs DATA_W+3 bits
  function automatic int mag_w(input int data_w);
    return data_w + 3;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_window_3x3.sv
// rtl/line_window_3x3.sv - line buffers, raster counters and 3x3 window registers
module line_window_3x3
  import sobel_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COL_NUM = 320,
  parameter int ROW_NUM = 720
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_valid,
  output logic                   o_origin,
  output logic [8:0][DATA_W-1:0] o_win,
  output logic                   o_win_valid,
  output logic                   o_sof,
  output logic                   o_eol,
  output logic                   o_eof
);

  localparam int CW = cnt_w(COL_NUM);
  localparam int RW = cnt_w(ROW_NUM);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb0 [COL_NUM];
  logic [DATA_W-1:0] r_lb1 [COL_NUM];
  logic [DATA_W-1:0] r_win [3][3];
  logic [DATA_W-1:0] w_up1;
  logic [DATA_W-1:0] w_up2;
  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_win_ok;

  // A pixel arriving together with reset is dropped
  assign w_accept   = i_valid && !i_rst;
  assign w_last_col = (r_col == CW'(COL_NUM - 1));
  assign w_last_row = (r_row == RW'(ROW_NUM - 1));
  assign w_win_ok   = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign o_origin   = (r_col == '0) && (r_row == '0);

  // lb0 holds the previous line, lb1 the line before that
  assign w_up1 = r_lb0[r_col];
  assign w_up2 = r_lb1[r_col];

  // Raster position of the next accepted pixel, wrapping at end of frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers cascade one line per write; contents are never reset
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= i_data;
      r_lb1[r_col] <= w_up1;
    end
  end

  // Window columns shift left; column 2 takes the newest vertical slice
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_up2;
      r_win[1][2] <= w_up1;
      r_win[2][2] <= i_data;
    end
  end

  // Window-valid and frame-position tags, aligned with the window registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_win_valid <= 1'b0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_eof       <= 1'b0;
    end else begin
      o_win_valid <= w_accept && w_win_ok;
      o_sof       <= w_accept && (r_row == RW'(2)) && (r_col == CW'(2));
      o_eol       <= w_accept && w_win_ok && w_last_col;
      o_eof       <= w_accept && w_win_ok && w_last_col && w_last_row;
    end
  end

  // Flatten the window as row*3+col, row 0 = top, col 0 = left
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        o_win[r*3+c] = r_win[r][c];
      end
    end
  end

endmodule

// File: rtl/sobel_edge_param.sv
// rtl/sobel_edge_param.sv - parametrised Sobel edge detector with per-frame threshold and mode
module sobel_edge_param
  import sobel_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int COL_NUM    = 320,
  parameter int ROW_NUM    = 720,
  parameter int THRESH_DEF = 80,
  localparam int MAG_W     = mag_w(DATA_W)
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pi_data,
  input  logic              pi_flag,
  input  logic [MAG_W-1:0]  thresh,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] po_data,
  output logic              po_flag,
  output logic              po_sof,
  output logic              po_eol,
  output logic              po_eof
);

  localparam logic [MAG_W-1:0]  PIX_MAX = MAG_W'((1 << DATA_W) - 1);
  localparam logic [DATA_W-1:0] ONES    = '1;

  logic [8:0][DATA_W-1:0] w_win;
  logic                   w_origin;
  tag_t                   w_tag1;
  logic [MAG_W-1:0]       w_left, w_right, w_top, w_bot;
  logic [DATA_W-1:0]      w_sel;

  logic [MAG_W-1:0]        r_thr;
  mode_e                   r_mode;
  tag_t                    r_tag2, r_tag3, r_tag4;
  logic signed [MAG_W-1:0] r_gx, r_gy;
  logic [MAG_W-1:0]        r_ax, r_ay, r_mag;
  logic [DATA_W-1:0]       r_ctr2, r_ctr3, r_ctr4;
  logic [MAG_W-1:0]        r_thr2, r_thr3, r_thr4;
  mode_e                   r_mode2, r_mode3, r_mode4;

  line_window_3x3 #(
    .DATA_W  (DATA_W),
    .COL_NUM (COL_NUM),
    .ROW_NUM (ROW_NUM)
  ) u_window (
    .i_clk       (sclk),
    .i_rst       (rst),
    .i_data      (pi_data),
    .i_valid     (pi_flag),
    .o_origin    (w_origin),
    .o_win       (w_win),
    .o_win_valid (w_tag1.valid),
    .o_sof       (w_tag1.sof),
    .o_eol       (w_tag1.eol),
    .o_eof       (w_tag1.eof)
  );

  // Weighted 1-2-1 column and row sums, zero-extended so nothing wraps
  assign w_left  = MAG_W'(w_win[0]) + MAG_W'({w_win[3], 1'b0}) + MAG_W'(w_win[6]);
  assign w_right = MAG_W'(w_win[2]) + MAG_W'({w_win[5], 1'b0}) + MAG_W'(w_win[8]);
  assign w_top   = MAG_W'(w_win[0]) + MAG_W'({w_win[1], 1'b0}) + MAG_W'(w_win[2]);
  assign w_bot   = MAG_W'(w_win[6]) + MAG_W'({w_win[7], 1'b0}) + MAG_W'(w_win[8]);

  // Threshold and mode are captured on the first pixel of each frame
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_thr  <= MAG_W'(THRESH_DEF);
      r_mode <= MODE_BIN;
    end else if (pi_flag && w_origin) begin
      r_thr  <= thresh;
      r_mode <= mode_e'(mode);
    end
  end

  // Tag pipeline; clearing it on reset discards in-flight results
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_tag4 <= '0;
    end else begin
      r_tag2 <= w_tag1;
      r_tag3 <= r_tag2;
      r_tag4 <= r_tag3;
    end
  end

  // Data pipeline: gradients, absolute values, magnitude; thr/mode ride along per result
  always_ff @(posedge sclk) begin
    r_gx    <= signed'(w_right - w_left);
    r_gy    <= signed'(w_top - w_bot);
    r_ctr2  <= w_win[4];
    r_thr2  <= r_thr;
    r_mode2 <= r_mode;

    r_ax    <= r_gx[MAG_W-1] ? unsigned'(-r_gx) : unsigned'(r_gx);
    r_ay    <= r_gy[MAG_W-1] ? unsigned'(-r_gy) : unsigned'(r_gy);
    r_ctr3  <= r_ctr2;
    r_thr3  <= r_thr2;
    r_mode3 <= r_mode2;

    r_mag   <= r_ax + r_ay;
    r_ctr4  <= r_ctr3;
    r_thr4  <= r_thr3;
    r_mode4 <= r_mode3;
  end

  // Output pixel selection for the mode in force when the frame started
  always_comb begin
    w_sel = '0;
    case (r_mode4)
      MODE_BIN:     w_sel = (r_mag >= r_thr4) ? '0 : ONES;
      MODE_BIN_INV: w_sel = (r_mag >= r_thr4) ? ONES : '0;
      MODE_MAG:     w_sel = (r_mag > PIX_MAX) ? ONES : r_mag[DATA_W-1:0];
      default:      w_sel = r_ctr4;
    endcase
  end

  // Output register; data holds between results, markers only with po_flag
  always_ff @(posedge sclk) begin
    if (rst) begin
      po_data <= '0;
      po_flag <= 1'b0;
      po_sof  <= 1'b0;
      po_eol  <= 1'b0;
      po_eof  <= 1'b0;
    end else begin
      po_flag <= r_tag4.valid;
      po_sof  <= r_tag4.valid && r_tag4.sof;
      po_eol  <= r_tag4.valid && r_tag4.eol;
      po_eof  <= r_tag4.valid && r_tag4.eof;
      if (r_tag4.valid) begin
        po_data <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_param.sv
// tb/tb_sobel_edge_param.sv - randomized self-checking bench against a frame-array reference model
module tb_sobel_edge_param;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int OUTS_PER_FRAME = (COLS - 2) * (ROWS - 2);

  logic        sclk = 1'b0;
  logic        rst = 1'b0;
  logic        pi_flag = 1'b0;
  logic [9:0]  pi_data = '0;
  logic [12:0] thresh_in = 13'd80;
  logic [1:0]  mode_in = 2'b00;

  logic [7:0]  po_data8;
  logic        po_flag8, po_sof8, po_eol8, po_eof8;
  logic [9:0]  po_data10;
  logic        po_flag10, po_sof10, po_eol10, po_eof10;

  always #5 sclk = ~sclk;

  sobel_edge_param #(.DATA_W(8), .COL_NUM(COLS), .ROW_NUM(ROWS), .THRESH_DEF(80)) u_dut8 (
    .sclk    (sclk),
    .rst     (rst),
    .pi_data (pi_data[7:0]),
    .pi_flag (pi_flag),
    .thresh  (thresh_in[10:0]),
    .mode    (mode_in),
    .po_data (po_data8),
    .po_flag (po_flag8),
    .po_sof  (po_sof8),
    .po_eol  (po_eol8),
    .po_eof  (po_eof8)
  );

  sobel_edge_param #(.DATA_W(10), .COL_NUM(COLS), .ROW_NUM(ROWS), .THRESH_DEF(80)) u_dut10 (
    .sclk    (sclk),
    .rst     (rst),
    .pi_data (pi_data),
    .pi_flag (pi_flag),
    .thresh  (thresh_in),
    .mode    (mode_in),
    .po_data (po_data10),
    .po_flag (po_flag10),
    .po_sof  (po_sof10),
    .po_eol  (po_eol10),
    .po_eof  (po_eof10)
  );

  typedef struct {
    int due;
    int data;
    bit sof;
    bit eol;
    bit eof;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   sel = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   base;
  int   img [ROWS][COLS];
  int   m_row = 0, m_col = 0, m_thr = 80, m_mode = 0;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, width sel %0d)", tag, got, exp, cyc, sel);
    end
  endtask

  function automatic int maxv();
    return (sel != 0) ? 1023 : 255;
  endfunction

  // Reference: store the frame, convolve the finished 3x3 neighbourhood directly
  task automatic model_accept(input int d);
    int   cr, cc, gx, gy, mag, o;
    exp_t e;
    img[m_row][m_col] = d;
    if (m_row == 0 && m_col == 0) begin
      m_thr  = (sel != 0) ? int'(thresh_in) : int'(thresh_in[10:0]);
      m_mode = int'(mode_in);
    end
    if (m_row >= 2 && m_col >= 2) begin
      cr = m_row - 1;
      cc = m_col - 1;
      gx = 0;
      gy = 0;
      for (int k = -1; k <= 1; k++) begin
        gx += ((k == 0) ? 2 : 1) * (img[cr+k][cc+1] - img[cr+k][cc-1]);
        gy += ((k == 0) ? 2 : 1) * (img[cr-1][cc+k] - img[cr+1][cc+k]);
      end
      mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      case (m_mode)
        0:       o = (mag >= m_thr) ? 0 : maxv();
        1:       o = (mag >= m_thr) ? maxv() : 0;
        2:       o = (mag > maxv()) ? maxv() : mag;
        default: o = img[cr][cc];
      endcase
      e.due  = cyc + 4;
      e.data = o;
      e.sof  = (m_row == 2 && m_col == 2);
      e.eol  = (m_col == COLS - 1);
      e.eof  = (m_col == COLS - 1) && (m_row == ROWS - 1);
      q.push_back(e);
    end
    if (m_col == COLS - 1) begin
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic monitor(input bit r);
    logic [9:0] d;
    logic       f, s, l, e;
    d = (sel != 0) ? po_data10 : {2'b00, po_data8};
    f = (sel != 0) ? po_flag10 : po_flag8;
    s = (sel != 0) ? po_sof10  : po_sof8;
    l = (sel != 0) ? po_eol10  : po_eol8;
    e = (sel != 0) ? po_eof10  : po_eof8;
    if (r) begin
      check("rst_flag", f, 0);
      check("rst_data", d, 0);
      check("rst_marks", {s, l, e}, 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      check("flag", f, 1);
      check("data", d, q[0].data);
      check("sof", s, q[0].sof);
      check("eol", l, q[0].eol);
      check("eof", e, q[0].eof);
      void'(q.pop_front());
      n_out++;
    end else if (f) begin
      check("spurious_flag", f, 0);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check just after it
  task automatic step(input bit r, input bit f, input int d);
    rst     = r;
    pi_flag = f;
    pi_data = 10'(d);
    @(posedge sclk);
    cyc++;
    if (r) begin
      q.delete();
      m_row  = 0;
      m_col  = 0;
      m_thr  = 80;
      m_mode = 0;
    end else if (f) begin
      model_accept(d);
    end
    #1;
    monitor(r);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 1023));
  endtask

  // kind 0 flat 100, kind 1 vertical step, kind 2 random pixels
  task automatic send_frame(input int kind, input int md, input int th, input int bub,
                            input int chg_at, input int th2, input int npix);
    int c, d;
    mode_in   = 2'(md);
    thresh_in = 13'(th);
    for (int i = 0; i < npix; i++) begin
      c = i % COLS;
      if (i == chg_at) thresh_in = 13'(th2);
      if (kind == 0)      d = 100;
      else if (kind == 1) d = (c < 4) ? 0 : ((sel != 0) ? 1023 : 200);
      else                d = $urandom_range(0, maxv());
      while ($urandom_range(0, 99) < bub) step(0, 0, $urandom_range(0, 1023));
      step(0, 1, d);
    end
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 1, 77);
    drain(3);

    base = n_out;
    send_frame(0, 0, 80, 0, -1, 0, COLS * ROWS);
    drain(8);
    check("flat_count", n_out - base, OUTS_PER_FRAME);

    base = n_out;
    send_frame(1, 2, 80, 0, -1, 0, COLS * ROWS);
    send_frame(1, 0, 80, 0, -1, 0, COLS * ROWS);
    drain(8);
    check("step_count", n_out - base, 2 * OUTS_PER_FRAME);

    base = n_out;
    send_frame(1, 0, 80, 50, -1, 0, COLS * ROWS);
    drain(8);
    check("bubble_count", n_out - base, OUTS_PER_FRAME);

    send_frame(1, 0, 80, 0, 24, 900, COLS * ROWS);
    send_frame(1, 0, 900, 0, -1, 0, COLS * ROWS);
    drain(8);

    send_frame(1, 2, 80, 0, -1, 0, 20);
    step(1, 1, 55);
    base = n_out;
    send_frame(1, 2, 80, 0, -1, 0, COLS * ROWS);
    drain(8);
    check("post_rst_count", n_out - base, OUTS_PER_FRAME);

    for (int f = 0; f < 4; f++)
      send_frame(2, $urandom_range(0, 3), $urandom_range(0, 2040), 30, -1, 0, COLS * ROWS);
    drain(8);

    sel = 1;
    step(1, 0, 0);
    base = n_out;
    send_frame(1, 2, 80, 0, -1, 0, COLS * ROWS);
    send_frame(1, 3, 80, 0, -1, 0, COLS * ROWS);
    for (int f = 0; f < 3; f++)
      send_frame(2, $urandom_range(0, 3), $urandom_range(0, 8184), 30, -1, 0, COLS * ROWS);
    drain(8);
    check("w10_count", n_out - base, 5 * OUTS_PER_FRAME);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
